// File: rtl/ila_readout.sv
// ---------------------------------------------------------------------------
// ila_readout
//
// Purpose:
//   Dumps the contents of an integrated logic analyzer's capture memory to a
//   downstream valid/ready consumer once a capture window is complete. The
//   dump starts at the oldest captured sample and walks the circular capture
//   memory, wrapping at the top of the address space. One sample is fetched,
//   waited on, and presented per transfer. When all samples have been handed
//   off, a one-cycle done/rearm pulse tells the analyzer it may capture again.
//   An abort or a reset discards the dump silently.
//
// Parameters:
//   DATA_WIDTH      sample width (matches the analyzer capture width)
//   ADDR_WIDTH      capture memory address width, DEPTH = 2**ADDR_WIDTH
//
// Ports:
//   clk             single clock, rising edge
//   reset           asynchronous, active-low reset
//   i_capture_done  capture memory holds a complete window (looked at in IDLE)
//   i_start_addr    address of the oldest captured sample
//   i_sample_count  number of samples to dump (clamped to DEPTH)
//   i_abort         cancel an in-progress dump
//   o_rd_en         capture memory read strobe
//   o_rd_addr       capture memory read address
//   i_rd_data       capture memory data, valid one cycle after o_rd_en
//   o_data          sample presented downstream
//   o_valid         o_data is valid
//   i_ready         downstream accepts o_data
//   o_busy          a dump is in progress
//   o_done          one-cycle pulse at normal dump completion
//   o_rearm         one-cycle pulse alongside o_done, re-primes the analyzer
// ---------------------------------------------------------------------------
module ila_readout #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_capture_done,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [ADDR_WIDTH:0]   i_sample_count,
  input  logic                  i_abort,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_rearm
);

  // Sample counts carry one extra bit so that a full memory (DEPTH samples)
  // is representable.
  localparam logic [ADDR_WIDTH:0] DepthCnt = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] OneCnt   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] ZeroCnt  = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]     rem_q, rem_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [ADDR_WIDTH:0]     clampedCount;
  logic                    transfer;

  // A request for more samples than the memory holds would otherwise re-read
  // the oldest samples a second time, so the count saturates at DEPTH.
  assign clampedCount = (i_sample_count > DepthCnt) ? DepthCnt : i_sample_count;

  // A handshake only counts while a sample is actually being presented.
  assign transfer = (state_q == S_PRESENT) && i_ready;

  // State register plus the datapath registers that travel with it. Reset
  // drops everything, so a dump interrupted by reset leaves no trace.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end

  // Next-state and datapath update. Abort is checked ahead of everything
  // else so it wins over a transfer landing on the same edge; the pointer
  // and remaining count are left alone because the next dump reloads them.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    data_d  = data_q;

    if ((state_q != S_IDLE) && i_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_capture_done) begin
            ptr_d   = i_start_addr;
            rem_d   = clampedCount;
            state_d = (clampedCount != ZeroCnt) ? S_READ : S_DONE;
          end
        end

        S_READ: begin
          state_d = S_WAIT;
        end

        // The memory answers one cycle after the strobe, so the sample is
        // captured on the edge that leaves WAIT and then held for PRESENT.
        S_WAIT: begin
          data_d  = i_rd_data;
          state_d = S_PRESENT;
        end

        // The pointer increment relies on natural ADDR_WIDTH overflow to
        // wrap from DEPTH-1 back to 0.
        S_PRESENT: begin
          if (transfer) begin
            ptr_d   = ptr_q + 1'b1;
            rem_d   = rem_q - OneCnt;
            state_d = (rem_q == OneCnt) ? S_DONE : S_READ;
          end
        end

        S_DONE: begin
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode from the registered state, so reset clears them at once.
  // The completion pulses are masked by abort so a dump cancelled in its
  // final cycle never reports completion.
  always_comb begin
    o_rd_en   = 1'b0;
    o_rd_addr = '0;
    o_valid   = 1'b0;
    o_busy    = 1'b1;
    o_done    = 1'b0;
    o_rearm   = 1'b0;

    case (state_q)
      S_IDLE: begin
        o_busy = 1'b0;
      end
      S_READ: begin
        o_rd_en   = 1'b1;
        o_rd_addr = ptr_q;
      end
      S_WAIT: begin
        o_rd_en = 1'b0;
      end
      S_PRESENT: begin
        o_valid = 1'b1;
      end
      S_DONE: begin
        o_done  = ~i_abort;
        o_rearm = ~i_abort;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  assign o_data = data_q;

endmodule

// File: tb/tb_ila_readout.sv
// Directed bench for ila_readout. A small capture memory model holds
// mem[a] = a + 0x10 with one-cycle read latency; a negedge monitor logs read
// strobes, accepted samples and completion pulses so each scenario can be
// compared against hand-computed address and data sequences.
module tb_ila_readout;

   localparam int DW = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          captureDone;
   logic [AW-1:0] startAddr;
   logic [AW:0]   sampleCount;
   logic          abort;
   logic          rdEn;
   logic [AW-1:0] rdAddr;
   logic [DW-1:0] rdData;
   logic [DW-1:0] dataOut;
   logic          valid;
   logic          ready;
   logic          busy;
   logic          done;
   logic          rearm;

   int checkCount = 0;
   int passCount  = 0;

   logic [DW-1:0] mem [16];
   logic [AW-1:0] rdAddrLog [$];
   logic [DW-1:0] xferLog [$];
   int doneCount   = 0;
   int rearmCount  = 0;
   int cyc         = 0;
   int lastXferCyc = 0;
   int lastDoneCyc = 0;

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   ila_readout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_capture_done (captureDone),
      .i_start_addr   (startAddr),
      .i_sample_count (sampleCount),
      .i_abort        (abort),
      .o_rd_en        (rdEn),
      .o_rd_addr      (rdAddr),
      .i_rd_data      (rdData),
      .o_data         (dataOut),
      .o_valid        (valid),
      .i_ready        (ready),
      .o_busy         (busy),
      .o_done         (done),
      .o_rearm        (rearm)
   );

   // Capture memory model: data appears one cycle after the strobe
   always @(posedge clk) begin
      if (rdEn) rdData <= mem[rdAddr];
   end

   // Monitor, sampling mid-cycle; an accepted sample is one where valid and
   // ready meet without an abort overriding the handshake
   always @(negedge clk) begin
      cyc++;
      if (rdEn) rdAddrLog.push_back(rdAddr);
      if (valid && ready && !abort) begin
         xferLog.push_back(dataOut);
         lastXferCyc = cyc;
      end
      if (done) begin
         doneCount++;
         lastDoneCyc = cyc;
      end
      if (rearm) rearmCount++;
   end

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   // Present one capture window and scramble the latch inputs afterwards so
   // the dump can only succeed if they were captured at latch time
   task automatic applyStimulus(input logic [AW-1:0] s, input logic [AW:0] n);
      startAddr   = s;
      sampleCount = n;
      captureDone = 1'b1;
      @(posedge clk);
      #1;
      captureDone = 1'b0;
      startAddr   = 4'hF;
      sampleCount = 5'd1;
   endtask

   // Wait (bounded) for a completion pulse, then confirm one was seen
   task automatic waitDone(input string tag, input int budget);
      int startCnt;
      startCnt = doneCount;
      for (int i = 0; i < budget && doneCount == startCnt; i++) begin
         @(negedge clk);
         #1;
      end
      checkOutput({tag, "_doneSeen"}, 32'(doneCount - startCnt), 32'd1);
   endtask

   initial begin
      int rb, xb, db, ab;
      for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16);
      reset       = 1'b0;
      captureDone = 1'b0;
      startAddr   = '0;
      sampleCount = '0;
      abort       = 1'b0;
      ready       = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_busy",  32'(busy),    32'd0);
      checkOutput("rst_valid", 32'(valid),   32'd0);
      checkOutput("rst_rdEn",  32'(rdEn),    32'd0);
      checkOutput("rst_addr",  32'(rdAddr),  32'd0);
      checkOutput("rst_data",  32'(dataOut), 32'd0);
      checkOutput("rst_done",  32'(done),    32'd0);
      checkOutput("rst_rearm", 32'(rearm),   32'd0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("postrst_idle", 32'(busy), 32'd0);
      checkOutput("postrst_noRead", 32'(rdAddrLog.size()), 32'd0);

      // Basic dump, start=2 count=4, with cycle-exact timing of the first beat
      rb = rdAddrLog.size(); xb = xferLog.size(); ab = rearmCount;
      applyStimulus(4'd2, 5'd4);
      @(negedge clk);
      checkOutput("basic_readEn",   32'(rdEn),   32'd1);
      checkOutput("basic_readAddr", 32'(rdAddr), 32'd2);
      checkOutput("basic_busy",     32'(busy),   32'd1);
      checkOutput("basic_readNoValid", 32'(valid), 32'd0);
      @(negedge clk);
      checkOutput("basic_waitNoRd",    32'(rdEn),  32'd0);
      checkOutput("basic_waitNoValid", 32'(valid), 32'd0);
      @(negedge clk);
      checkOutput("basic_firstValid", 32'(valid),   32'd1);
      checkOutput("basic_firstData",  32'(dataOut), 32'h12);
      waitDone("basic", 50);
      checkOutput("basic_rearm", 32'(rearm), 32'd1);
      checkOutput("basic_nRd",   32'(rdAddrLog.size() - rb), 32'd4);
      checkOutput("basic_nXfer", 32'(xferLog.size() - xb),   32'd4);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("basic_addr%0d", k), 32'(rdAddrLog[rb + k]), 32'(2 + k));
         checkOutput($sformatf("basic_data%0d", k), 32'(xferLog[xb + k]),   32'(8'h12 + k));
      end
      checkOutput("basic_doneLatency", 32'(lastDoneCyc - lastXferCyc), 32'd1);
      @(negedge clk);
      checkOutput("basic_doneOneCycle", 32'(done), 32'd0);
      checkOutput("basic_backIdle",     32'(busy), 32'd0);
      checkOutput("basic_rearmCount",   32'(rearmCount - ab), 32'd1);

      // Wrap-around, start=14 count=4
      rb = rdAddrLog.size(); xb = xferLog.size();
      applyStimulus(4'd14, 5'd4);
      waitDone("wrap", 50);
      checkOutput("wrap_nRd", 32'(rdAddrLog.size() - rb), 32'd4);
      checkOutput("wrap_addr0", 32'(rdAddrLog[rb + 0]), 32'd14);
      checkOutput("wrap_addr1", 32'(rdAddrLog[rb + 1]), 32'd15);
      checkOutput("wrap_addr2", 32'(rdAddrLog[rb + 2]), 32'd0);
      checkOutput("wrap_addr3", 32'(rdAddrLog[rb + 3]), 32'd1);
      checkOutput("wrap_data2", 32'(xferLog[xb + 2]),   32'h10);
      @(negedge clk);

      // Backpressure on the first beat for 5 cycles
      rb = rdAddrLog.size(); xb = xferLog.size();
      ready = 1'b0;
      applyStimulus(4'd2, 5'd4);
      for (int i = 0; i < 10 && !valid; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("bp_valid%0d", i), 32'(valid),   32'd1);
         checkOutput($sformatf("bp_data%0d", i),  32'(dataOut), 32'h12);
         @(negedge clk);
      end
      checkOutput("bp_noExtraRead", 32'(rdAddrLog.size() - rb), 32'd1);
      ready = 1'b1;
      waitDone("bp", 50);
      checkOutput("bp_nXfer", 32'(xferLog.size() - xb), 32'd4);
      checkOutput("bp_data0", 32'(xferLog[xb + 0]), 32'h12);
      checkOutput("bp_data3", 32'(xferLog[xb + 3]), 32'h15);
      @(negedge clk);

      // Zero-length dump: straight to completion, no read strobe
      rb = rdAddrLog.size();
      applyStimulus(4'd5, 5'd0);
      @(negedge clk);
      checkOutput("zero_done",  32'(done),  32'd1);
      checkOutput("zero_rearm", 32'(rearm), 32'd1);
      checkOutput("zero_busy",  32'(busy),  32'd1);
      @(negedge clk);
      checkOutput("zero_doneOff", 32'(done), 32'd0);
      checkOutput("zero_idle",    32'(busy), 32'd0);
      checkOutput("zero_noRead",  32'(rdAddrLog.size() - rb), 32'd0);

      // Oversized count is clamped to the memory depth
      rb = rdAddrLog.size(); xb = xferLog.size();
      applyStimulus(4'd3, 5'd20);
      waitDone("clamp", 200);
      checkOutput("clamp_nXfer", 32'(xferLog.size() - xb),   32'd16);
      checkOutput("clamp_nRd",   32'(rdAddrLog.size() - rb), 32'd16);
      checkOutput("clamp_firstAddr", 32'(rdAddrLog[rb]),      32'd3);
      checkOutput("clamp_lastAddr",  32'(rdAddrLog[rb + 15]), 32'd2);
      checkOutput("clamp_lastData",  32'(xferLog[xb + 15]),   32'h12);
      @(negedge clk);

      // Abort on the second presented sample
      rb = rdAddrLog.size(); xb = xferLog.size(); db = doneCount; ab = rearmCount;
      applyStimulus(4'd0, 5'd4);
      repeat (6) @(negedge clk);
      checkOutput("abort_2ndValid", 32'(valid),   32'd1);
      checkOutput("abort_2ndData",  32'(dataOut), 32'h11);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abort_validDrop", 32'(valid), 32'd0);
      checkOutput("abort_idle",      32'(busy),  32'd0);
      repeat (5) @(negedge clk);
      checkOutput("abort_noDone",  32'(doneCount - db),  32'd0);
      checkOutput("abort_noRearm", 32'(rearmCount - ab), 32'd0);
      checkOutput("abort_nRd",     32'(rdAddrLog.size() - rb), 32'd2);
      checkOutput("abort_nXfer",   32'(xferLog.size() - xb),   32'd1);

      // A fresh dump after abort reloads pointer and count
      rb = rdAddrLog.size(); xb = xferLog.size();
      applyStimulus(4'd9, 5'd1);
      waitDone("reDump", 50);
      checkOutput("reDump_addr", 32'(rdAddrLog[rb]), 32'd9);
      checkOutput("reDump_data", 32'(xferLog[xb]),   32'h19);
      @(negedge clk);

      // capture_done while busy must not restart or extend the dump
      rb = rdAddrLog.size();
      applyStimulus(4'd4, 5'd2);
      @(negedge clk);
      startAddr   = 4'd9;
      sampleCount = 5'd3;
      captureDone = 1'b1;
      @(posedge clk);
      #1;
      captureDone = 1'b0;
      waitDone("busyIgnore", 50);
      repeat (4) @(negedge clk);
      checkOutput("busyIgnore_nRd",  32'(rdAddrLog.size() - rb), 32'd2);
      checkOutput("busyIgnore_addr0", 32'(rdAddrLog[rb + 0]), 32'd4);
      checkOutput("busyIgnore_addr1", 32'(rdAddrLog[rb + 1]), 32'd5);
      checkOutput("busyIgnore_idle",  32'(busy), 32'd0);

      // Reset in the middle of a dump clears outputs at once and discards it
      rb = rdAddrLog.size(); db = doneCount;
      applyStimulus(4'd6, 5'd4);
      repeat (3) @(negedge clk);
      checkOutput("midRst_preData", 32'(dataOut), 32'h16);
      reset = 1'b0;
      #1;
      checkOutput("midRst_valid", 32'(valid),   32'd0);
      checkOutput("midRst_busy",  32'(busy),    32'd0);
      checkOutput("midRst_data",  32'(dataOut), 32'd0);
      checkOutput("midRst_rdEn",  32'(rdEn),    32'd0);
      checkOutput("midRst_done",  32'(done),    32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("midRst_noDone", 32'(doneCount - db), 32'd0);
      checkOutput("midRst_nRd",    32'(rdAddrLog.size() - rb), 32'd1);
      checkOutput("midRst_idle",   32'(busy), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   // Watchdog so the run always ends on its own
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
